// File: rtl/demux3_1_pipe_pkg.sv
// Shared constants for the result router and the forwarding-mux select logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demux3_1_pipe_pkg;

  localparam int WIDTH_DEF = 16;

  // Destination select codes, same encoding the 3:1 forwarding mux consumes.
  typedef enum logic [1:0] {
    SEL_D0   = 2'd0,
    SEL_D1   = 2'd1,
    SEL_D2   = 2'd2,
    SEL_DROP = 2'd3
  } sel_e;

endpackage

// File: rtl/demux3_1_pipe_fifo2.sv
// Two-entry synchronous FIFO with registered head.
// Latency: a push is visible on head one cycle later.
// Backpressure: push ignored when full unless a pop frees a slot the same cycle.
module fifo2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  logic [1:0]   cnt;
  logic [W-1:0] mem0;   // head slot
  logic [W-1:0] mem1;   // second slot
  logic         push_ok;
  logic         pop_ok;

  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign head  = mem0;

  // Qualify requests against occupancy so the FIFO protects itself.
  always_comb begin
    push_ok = push && (!full || pop);
    pop_ok  = pop && !empty;
  end

  // Storage and occupancy update; the head slot always holds the oldest word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 2'd0;
      mem0 <= '0;
      mem1 <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt == 2'd0) mem0 <= din;
          else             mem1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          mem0 <= mem1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // Count unchanged; the new word lands behind whatever remains.
          if (cnt == 2'd1) begin
            mem0 <= din;
          end else begin
            mem0 <= mem1;
            mem1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/demux3_1_pipe.sv
// Routes one valid/ready stream to d0/d1/d2 by select; select 3 drops and counts.
// Latency: 1 cycle from input accept to destination valid.
// Backpressure: in_ready follows only the selected FIFO's full flag; drops always accepted.
module demux3_1_pipe
  import demux3_1_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic             d0_valid,
  input  logic             d0_ready,
  output logic [WIDTH-1:0] d0_data,
  output logic             d1_valid,
  input  logic             d1_ready,
  output logic [WIDTH-1:0] d1_data,
  output logic             d2_valid,
  input  logic             d2_ready,
  output logic [WIDTH-1:0] d2_data,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [2:0]       push;
  logic [2:0]       pop;
  logic [2:0]       full;
  logic [2:0]       empty;
  logic [WIDTH-1:0] head [3];
  logic             accept;
  logic             drop_vld;

  assign pop = {d2_ready, d1_ready, d0_ready};

  // Ready mux: only the selected FIFO's fullness matters; drops never stall.
  always_comb begin
    in_ready = 1'b1;
    case (sel_e'(in_sel))
      SEL_D0:  in_ready = !full[0];
      SEL_D1:  in_ready = !full[1];
      SEL_D2:  in_ready = !full[2];
      default: in_ready = 1'b1;
    endcase
  end

  // Select decode into per-FIFO push enables and the drop strobe.
  always_comb begin
    accept   = in_valid && in_ready;
    push     = 3'b000;
    drop_vld = 1'b0;
    case (sel_e'(in_sel))
      SEL_D0:  push[0]  = accept;
      SEL_D1:  push[1]  = accept;
      SEL_D2:  push[2]  = accept;
      default: drop_vld = accept;
    endcase
  end

  for (genvar k = 0; k < 3; k++) begin : g_fifo
    fifo2 #(.W(WIDTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[k]),
      .din   (in_data),
      .pop   (pop[k]),
      .full  (full[k]),
      .empty (empty[k]),
      .head  (head[k])
    );
  end

  assign d0_valid = !empty[0];
  assign d1_valid = !empty[1];
  assign d2_valid = !empty[2];
  assign d0_data  = head[0];
  assign d1_data  = head[1];
  assign d2_data  = head[2];

  // Saturating count of discarded words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop_vld && (drop_cnt != {CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux3_1_pipe.sv
// Self-checking bench for demux3_1_pipe against a queue-based reference model.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: sinks driven per step, including stalled and random ready.
module tb_demux3_1_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        d0_valid, d1_valid, d2_valid;
  logic        d0_ready, d1_ready, d2_ready;
  logic [15:0] d0_data, d1_data, d2_data;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per destination plus a drop tally.
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  int          drops = 0;

  demux3_1_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .d0_valid (d0_valid),
    .d0_ready (d0_ready),
    .d0_data  (d0_data),
    .d1_valid (d1_valid),
    .d1_ready (d1_ready),
    .d1_data  (d1_data),
    .d2_valid (d2_valid),
    .d2_ready (d2_ready),
    .d2_data  (d2_data),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int k);
    if (k == 0) return q0.size();
    if (k == 1) return q1.size();
    return q2.size();
  endfunction

  function automatic logic [15:0] qhead(input int k);
    if (k == 0) return q0[0];
    if (k == 1) return q1[0];
    return q2[0];
  endfunction

  task automatic check_outputs(input string tag);
    logic [2:0]  v;
    logic [15:0] d [3];
    v = {d2_valid, d1_valid, d0_valid};
    d[0] = d0_data; d[1] = d1_data; d[2] = d2_data;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_d%0d_valid", tag, k), {31'd0, v[k]}, (qsize(k) > 0) ? 32'd1 : 32'd0);
      if (qsize(k) > 0)
        chk($sformatf("%s_d%0d_data", tag, k), {16'd0, d[k]}, {16'd0, qhead(k)});
    end
    chk({tag, "_drop_cnt"}, {24'd0, drop_cnt}, drops);
  endtask

  // One clock of stimulus: drive, check ready, advance model at the edge, check outputs.
  task automatic cycle(input logic v, input logic [1:0] s, input logic [15:0] dat,
                       input logic [2:0] rdy, input string tag);
    logic exp_rdy;
    in_valid = v; in_sel = s; in_data = dat;
    {d2_ready, d1_ready, d0_ready} = rdy;
    #1;
    exp_rdy = (s == 2'd3) || (qsize(int'(s)) < 2);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    if (rdy[0] && q0.size() > 0) void'(q0.pop_front());
    if (rdy[1] && q1.size() > 0) void'(q1.pop_front());
    if (rdy[2] && q2.size() > 0) void'(q2.pop_front());
    if (v && exp_rdy) begin
      case (s)
        2'd0: q0.push_back(dat);
        2'd1: q1.push_back(dat);
        2'd2: q2.push_back(dat);
        default: if (drops < 255) drops++;
      endcase
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic probe_ready(input logic [1:0] s, input logic exp, input string tag);
    in_valid = 1'b0; in_sel = s;
    #1;
    chk(tag, {31'd0, in_ready}, {31'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 16'd0;
    d0_ready = 1'b0; d1_ready = 1'b0; d2_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_d0_valid", {31'd0, d0_valid}, 0);
    chk("rst_d1_valid", {31'd0, d1_valid}, 0);
    chk("rst_d2_valid", {31'd0, d2_valid}, 0);
    chk("rst_data", {16'd0, d0_data | d1_data | d2_data}, 0);
    chk("rst_drop_cnt", {24'd0, drop_cnt}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic routing
    cycle(1'b1, 2'd0, 16'd10,  3'b111, "route0");
    chk("route0_exact", {16'd0, d0_data}, 32'd10);
    cycle(1'b1, 2'd1, 16'd22,  3'b111, "route1");
    chk("route1_exact", {16'd0, d1_data}, 32'd22);
    cycle(1'b1, 2'd2, 16'd764, 3'b111, "route2");
    chk("route2_exact", {16'd0, d2_data}, 32'd764);
    cycle(1'b0, 2'd0, 16'd0,   3'b111, "route_idle");

    // Illegal select
    for (int i = 0; i < 5; i++) cycle(1'b1, 2'd3, 16'(i), 3'b111, "drop");
    chk("drop_five", {24'd0, drop_cnt}, 32'd5);

    // Back-pressure on d1
    cycle(1'b1, 2'd1, 16'd1, 3'b101, "bp_1");
    cycle(1'b1, 2'd1, 16'd2, 3'b101, "bp_2");
    cycle(1'b1, 2'd1, 16'd3, 3'b101, "bp_3_stall");
    probe_ready(2'd1, 1'b0, "bp_sel1_blocked");
    probe_ready(2'd0, 1'b1, "bp_sel0_open");
    probe_ready(2'd2, 1'b1, "bp_sel2_open");
    chk("bp_head1", {16'd0, d1_data}, 32'd1);
    cycle(1'b1, 2'd1, 16'd3, 3'b111, "bp_release");
    chk("bp_head2", {16'd0, d1_data}, 32'd2);
    cycle(1'b1, 2'd1, 16'd3, 3'b111, "bp_accept3");
    chk("bp_head3", {16'd0, d1_data}, 32'd3);
    cycle(1'b0, 2'd1, 16'd0, 3'b111, "bp_drain");

    // Steady stream on d0
    for (int i = 0; i < 100; i++) cycle(1'b1, 2'd0, 16'(1000 + i), 3'b111, "stream");
    cycle(1'b0, 2'd0, 16'd0, 3'b111, "stream_drain");

    // Randomized traffic with random sink stalls
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
            3'($urandom_range(0, 7)), "rand");

    // Saturation
    for (int i = 0; i < 300; i++) cycle(1'b1, 2'd3, 16'd0, 3'b111, "sat");
    chk("sat_255", {24'd0, drop_cnt}, 32'd255);

    // Reset mid-operation
    cycle(1'b0, 2'd2, 16'd0,     3'b111, "pre_rst_drain");
    cycle(1'b0, 2'd2, 16'd0,     3'b111, "pre_rst_drain2");
    cycle(1'b1, 2'd2, 16'h1111,  3'b000, "fill_a");
    cycle(1'b1, 2'd2, 16'h2222,  3'b000, "fill_b");
    chk("fill_full", {31'd0, in_ready}, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    q0.delete(); q1.delete(); q2.delete(); drops = 0;
    chk("arst_d0_valid", {31'd0, d0_valid}, 0);
    chk("arst_d1_valid", {31'd0, d1_valid}, 0);
    chk("arst_d2_valid", {31'd0, d2_valid}, 0);
    chk("arst_drop_cnt", {24'd0, drop_cnt}, 0);
    chk("arst_d2_data", {16'd0, d2_data}, 0);
    #1 rst_n = 1'b1;
    cycle(1'b1, 2'd2, 16'hBEEF, 3'b000, "post_rst");
    chk("post_rst_head", {16'd0, d2_data}, 32'hBEEF);
    cycle(1'b0, 2'd2, 16'd0, 3'b100, "post_rst_pop");
    chk("post_rst_alone", {31'd0, d2_valid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux3_1_pipe.md
# demux3_1_pipe

Registered 1-to-3 result router for the pipelined datapath. It steers one 16-bit valid/ready stream to one of three destination ports chosen by a 2-bit select, using the same 0/1/2 encoding that the 3:1 forwarding mux consumes. Each destination has a 2-entry FIFO, so back-pressure on one port does not block traffic to the others. Select code 3 is illegal; the block drops the word and counts the drop.

## Interface
- `WIDTH`, default 16: data width of all data ports.
- `CNT_W`, default 8: width of the saturating drop counter.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  input word accepted this cycle when high together with `in_valid`.
- `in_data`  in  WIDTH  input word.
- `in_sel`  in  2  destination select: 0 routes to `d0`, 1 to `d1`, 2 to `d2`, 3 drops the word.
- `d0_valid`, `d1_valid`, `d2_valid`  out  1 each  head of FIFO *k* is valid.
- `d0_ready`, `d1_ready`, `d2_ready`  in  1 each  sink *k* accepts the head.
- `d0_data`, `d1_data`, `d2_data`  out  WIDTH each  head of FIFO *k*.
- `drop_cnt`  out  CNT_W  number of words accepted with `in_sel`=3; saturates at all-ones.

## Operation
- Transfer on any port occurs when valid and ready are both high at the clock edge.
- `in_ready` depends on `in_sel` and registered FIFO state:
  - For `in_sel`=k (0..2), `in_ready` is high when FIFO *k* is not full.
  - For `in_sel`=3, `in_ready` is always high.
- `in_ready` does not depend on any `dk_ready`. There is no same-cycle pass-through when a FIFO is full.
- An accepted word with `in_sel`=k is pushed into FIFO *k*.
- An accepted word with `in_sel`=3 is discarded, and `drop_cnt` increments by 1, stopping at 2^CNT_W−1.
- Each FIFO is 2 entries deep and first-in first-out. `dk_valid` is high iff the FIFO is not empty, and `dk_data` is its head.
- Simultaneous push and pop on a full FIFO is not possible, because `in_ready` is low when the FIFO is full.
- Simultaneous push and pop on a FIFO holding one entry leaves the count at 1; the new word becomes the head on the next cycle.
- Simultaneous push and pop on an empty FIFO cannot occur (pop requires valid).
- The three FIFOs are independent. A stalled sink affects only words selected to that sink.
- Ordering is preserved per destination. No ordering is defined across destinations.
- `dk_valid` and `dk_data` are register outputs. Once valid, `dk_data` holds stable until it is popped.

## Timing
- Latency is 1 cycle: a word accepted at edge N is visible on `dk_valid`/`dk_data` after edge N.
- Throughput is 1 word/cycle per destination while its sink holds ready high.
- Reset (`rst_n` low, asynchronous):
  - All FIFOs empty, so `d0_valid`, `d1_valid`, `d2_valid` = 0.
  - `d0_data`, `d1_data`, `d2_data` = 0.
  - `drop_cnt` = 0.
  - `in_ready` evaluates from the empty state, i.e. 1.
- Reset asserted mid-operation flushes all FIFOs and the counter immediately. Words in flight are lost and are not counted.
- Reset deassertion is synchronous to `clk`, handled by the system reset synchronizer. The first transfer is allowed on the first edge after deassertion.

## Structure
- Shared package holds:
  - `WIDTH` default (16).
  - Select encodings `SEL_D0`=0, `SEL_D1`=1, `SEL_D2`=2, `SEL_DROP`=3, shared with the forwarding-mux select logic.
- One sub-module, `fifo2`: a parameterized 2-entry synchronous FIFO.
  - Push/pop ports, `full`, `empty` and `head`.
  - Asynchronous active-low reset.
  - Instantiated three times.
- The top level contains only select decode, `in_ready` mux, push-enable generation and the drop counter.

## Test plan
- **Basic routing:** with all `dk_ready`=1, send 10/sel0, 22/sel1, 764/sel2 on consecutive cycles. Each word appears one cycle later on `d0`, `d1`, `d2` respectively. `drop_cnt` stays 0.
- **Illegal select:** send 5 words with sel=3. `in_ready` stays 1 throughout, no `dk_valid` asserts, and `drop_cnt`=5.
- **Back-pressure:** hold `d1_ready`=0 and send 1,2,3 to sel1.
  - After two accepts, `in_ready` drops for sel1 but remains 1 for sel0 and sel2.
  - Releasing `d1_ready` yields 1 then 2, after which 3 is accepted.
- **Steady stream:** with `d0_ready`=1, stream 100 sequential words to sel0. Expect 1 word/cycle with no bubbles and in-order output.
- **Saturation:** with CNT_W=8, send 300 sel=3 words. `drop_cnt`=255.
- **Reset mid-operation:** fill FIFO 2 with two words, then pulse `rst_n` low asynchronously between edges. All `dk_valid` go 0 immediately, `drop_cnt`=0, and a subsequent sel2 word emerges alone.
